// File: rtl/joybus_pkg.sv
// Shared types, command constants and quarter-bit encoding for the Joybus command path.
package joybus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_STOP,
    ST_WAIT
  } state_t;

  localparam logic [7:0]  CMD_STATUS      = 8'h00;
  localparam logic [23:0] CMD_POLL        = 24'h400302;
  localparam logic [7:0]  WB_ID_WIRED     = 8'h09;
  localparam logic [7:0]  WB_ID_NOT_READY = 8'hA8;

  // 1 = line pulled low during quarter q of a data bit: '0' is 3 low + 1 high, '1' is 1 low + 3 high.
  function automatic logic bit_low(input logic b, input logic [1:0] q);
    return b ? (q == 2'd0) : (q != 2'd3);
  endfunction

endpackage

// File: rtl/joybus_quarter_tick.sv
// Quarter-bit timebase: o_tick on the last cycle of each quarter, o_pre_tick one cycle earlier.
module joybus_quarter_tick #(
  parameter int Q_CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick,
  output logic o_pre_tick
);

  localparam int CNT_W = $clog2(Q_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == CNT_W'(Q_CYCLES - 1))) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick     = (r_cnt == CNT_W'(Q_CYCLES - 1));
  assign o_pre_tick = (r_cnt == CNT_W'(Q_CYCLES - 2));

endmodule

// File: rtl/joybus_cmd_tx.sv
// Joybus command transmitter: serialises 1..MAX_BYTES bytes plus stop bit, then waits for reply or timeout.
// state | meaning
// IDLE  | ready for a command      SEND | data bits on the line
// STOP  | 2-quarter stop bit       WAIT | watching for reply start edge
module joybus_cmd_tx
  import joybus_pkg::*;
#(
  parameter int Q_CYCLES  = 100,
  parameter int MAX_BYTES = 3,
  parameter int RESP_TO_Q = 400,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*MAX_BYTES-1:0] i_cmd_data,
  input  logic [LEN_W-1:0]       i_cmd_len,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_abort,
  input  logic                   i_line_in,
  output logic                   o_data_oe,
  output logic                   o_send,
  output logic                   o_done,
  output logic                   o_resp_start,
  output logic                   o_resp_timeout
);

  localparam int TOTAL_BITS = 8 * MAX_BYTES;
  localparam int BIT_W      = $clog2(TOTAL_BITS);
  localparam int WAIT_W     = $clog2(RESP_TO_Q + 1);

  state_t                r_state;
  logic [TOTAL_BITS-1:0] r_data;
  logic [BIT_W-1:0]      r_bit;
  logic [BIT_W-1:0]      r_last;
  logic [1:0]            r_q;
  logic [WAIT_W-1:0]     r_wcnt;
  logic                  r_sync1, r_sync2, r_line_prev;
  logic                  r_cmd_ready, r_data_oe, r_send, r_done, r_resp_start, r_resp_timeout;

  logic [LEN_W-1:0] w_len;
  logic [BIT_W-1:0] w_last;
  logic             w_accept, w_cur_bit, w_fall, w_tick, w_pre_tick;

  assign w_len      = (i_cmd_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : i_cmd_len;
  assign w_last     = BIT_W'((int'(w_len) * 8) - 1);
  assign w_accept   = (r_state == ST_IDLE) && r_cmd_ready && i_cmd_valid && !i_abort;
  assign w_cur_bit  = r_data[BIT_W'(TOTAL_BITS - 1) - r_bit];
  assign w_fall     = r_line_prev && !r_sync2;

  joybus_quarter_tick #(.Q_CYCLES(Q_CYCLES)) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_restart  (w_accept || i_abort),
    .o_tick     (w_tick),
    .o_pre_tick (w_pre_tick)
  );

  // Idle-high line: synchroniser resets to 1 so reset release is not seen as a reply edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_line_prev <= 1'b1;
    end else begin
      r_sync1     <= i_line_in;
      r_sync2     <= r_sync1;
      r_line_prev <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_data         <= '0;
      r_bit          <= '0;
      r_last         <= '0;
      r_q            <= '0;
      r_wcnt         <= '0;
      r_cmd_ready    <= 1'b0;
      r_data_oe      <= 1'b0;
      r_send         <= 1'b0;
      r_done         <= 1'b0;
      r_resp_start   <= 1'b0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_done         <= 1'b0;
      r_resp_start   <= 1'b0;
      r_resp_timeout <= 1'b0;
      if (i_abort) begin
        r_state     <= ST_IDLE;
        r_cmd_ready <= 1'b0;
        r_data_oe   <= 1'b0;
        r_send      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cmd_ready <= 1'b1;
            if (w_accept) begin
              r_cmd_ready <= 1'b0;
              r_data      <= i_cmd_data;
              r_last      <= w_last;
              r_bit       <= '0;
              r_q         <= '0;
              r_wcnt      <= '0;
              r_data_oe   <= 1'b1;
              r_send      <= 1'b1;
              r_state     <= (w_len == '0) ? ST_STOP : ST_SEND;
            end
          end
          ST_SEND: begin
            if (w_tick) begin
              if (r_q == 2'd3) begin
                r_q       <= '0;
                r_data_oe <= 1'b1;
                if (r_bit == r_last) r_state <= ST_STOP;
                else r_bit <= r_bit + 1'b1;
              end else begin
                r_q       <= r_q + 2'd1;
                r_data_oe <= bit_low(w_cur_bit, r_q + 2'd1);
              end
            end
          end
          ST_STOP: begin
            // done must land on the final cycle of the frame, one cycle before the quarter tick.
            if (w_pre_tick && (r_q == 2'd1)) r_done <= 1'b1;
            if (w_tick) begin
              if (r_q == 2'd0) begin
                r_q       <= 2'd1;
                r_data_oe <= 1'b0;
              end else begin
                r_state <= ST_WAIT;
                r_send  <= 1'b0;
                r_wcnt  <= '0;
              end
            end
          end
          ST_WAIT: begin
            if (w_fall) begin
              r_state      <= ST_IDLE;
              r_resp_start <= 1'b1;
            end else if (w_tick) begin
              if (r_wcnt == WAIT_W'(RESP_TO_Q - 1)) begin
                r_state        <= ST_IDLE;
                r_resp_timeout <= 1'b1;
              end else begin
                r_wcnt <= r_wcnt + 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_cmd_ready    = r_cmd_ready;
  assign o_data_oe      = r_data_oe;
  assign o_send         = r_send;
  assign o_done         = r_done;
  assign o_resp_start   = r_resp_start;
  assign o_resp_timeout = r_resp_timeout;

endmodule
